fifo_level: RTL and testbench

Parametrised synchronous FIFO with any depth ≥ 2, occupancy count, programmable almost-full/almost-empty flags, protected push/pop and sticky overflow/underflow error flags. Successor to the basic power-of-two FIFO; used between the UART receive/transmit paths and the interface/ALU control logic wherever back-pressure visibility is needed. Single clock domain, first-word-fall-through read.

---
 rtl/fifo_level_pkg.sv | 19 +
 rtl/fifo_level_ptr.sv | 49 ++++
 rtl/fifo_level.sv | 147 ++++++++++++++
 tb/tb_fifo_level.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_level_pkg.sv
// rtl/fifo_level_pkg.sv - shared width helpers for the fifo_level slice
//
// Purpose: constant functions used by fifo_level and its pointer sub-module
// to size pointers and the occupancy counter from the buffer depth.
// Ports: none (package).

package fifo_level_pkg;

  // Pointer width for an index range 0..depth-1; never narrower than 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width able to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_level_ptr.sv
// rtl/fifo_level_ptr.sv - wrapping index pointer for fifo_level
//
// Purpose: holds a read or write index in 0..N_WORD_BUFFER-1 and wraps
// explicitly to 0, so the depth need not be a power of two.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset (pointer -> 0)
//   i_inc    advance pointer by one with wrap
//   i_clr    synchronous clear to 0 (wins over i_inc)
//   o_ptr    current pointer value

module fifo_level_ptr
  import fifo_level_pkg::*;
#(
  parameter  int N_WORD_BUFFER = 4,
  localparam int NB_PTR        = ptr_width(N_WORD_BUFFER)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [NB_PTR-1:0] o_ptr
);

  localparam logic [NB_PTR-1:0] PTR_LAST = NB_PTR'(N_WORD_BUFFER - 1);

  logic [NB_PTR-1:0] ptr_q;
  logic [NB_PTR-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_inc) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + NB_PTR'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - synchronous FWFT FIFO with occupancy and level flags
//
// Purpose: single-clock first-word-fall-through FIFO of any depth >= 2 with
// an occupancy count, programmable almost-full/almost-empty thresholds,
// protected push/pop and sticky overflow/underflow flags.
// Ports:
//   i_clk, i_rst_n     clock (rising) and asynchronous active-low reset
//   i_data             write word
//   i_write / i_read   push / pop requests
//   i_flush            synchronous clear of pointers and count
//   i_clr_err          synchronous clear of the sticky error flags
//   o_data             word at head of queue (valid when not empty)
//   o_fifo_empty/full  count == 0 / count == N_WORD_BUFFER
//   o_almost_empty     count <= N_ALMOST_EMPTY
//   o_almost_full      count >= N_ALMOST_FULL
//   o_count            current occupancy
//   o_overflow         sticky: a push was rejected
//   o_underflow        sticky: a pop was rejected

module fifo_level
  import fifo_level_pkg::*;
#(
  parameter  int NB_WORD        = 8,
  parameter  int N_WORD_BUFFER  = 4,
  parameter  int N_ALMOST_FULL  = N_WORD_BUFFER - 1,
  parameter  int N_ALMOST_EMPTY = 1,
  localparam int NB_COUNT       = count_width(N_WORD_BUFFER)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NB_WORD-1:0]  i_data,
  input  logic                i_write,
  input  logic                i_read,
  input  logic                i_flush,
  input  logic                i_clr_err,
  output logic [NB_WORD-1:0]  o_data,
  output logic                o_fifo_empty,
  output logic                o_fifo_full,
  output logic                o_almost_empty,
  output logic                o_almost_full,
  output logic [NB_COUNT-1:0] o_count,
  output logic                o_overflow,
  output logic                o_underflow
);

  localparam int NB_PTR = ptr_width(N_WORD_BUFFER);

  localparam logic [NB_COUNT-1:0] COUNT_FULL = NB_COUNT'(N_WORD_BUFFER);
  localparam logic [NB_COUNT-1:0] COUNT_AF   = NB_COUNT'(N_ALMOST_FULL);
  localparam logic [NB_COUNT-1:0] COUNT_AE   = NB_COUNT'(N_ALMOST_EMPTY);

  logic [NB_WORD-1:0]  mem_q [N_WORD_BUFFER];
  logic [NB_PTR-1:0]   rd_ptr;
  logic [NB_PTR-1:0]   wr_ptr;
  logic [NB_COUNT-1:0] count_q;
  logic [NB_COUNT-1:0] count_d;
  logic                overflow_q;
  logic                overflow_d;
  logic                underflow_q;
  logic                underflow_d;

  logic empty;
  logic full;
  logic wr_acc;
  logic rd_acc;
  logic wr_rej;
  logic rd_rej;

  assign empty = (count_q == '0);
  assign full  = (count_q == COUNT_FULL);

  // A flush swallows the same-cycle requests: nothing is accepted and
  // nothing counts as rejected. When full, a simultaneous accepted pop
  // frees the slot the push lands in.
  assign rd_acc = i_read  & ~empty & ~i_flush;
  assign wr_acc = i_write & (~full | rd_acc) & ~i_flush;
  assign rd_rej = i_read  & ~rd_acc & ~i_flush;
  assign wr_rej = i_write & ~wr_acc & ~i_flush;

  fifo_level_ptr #(
    .N_WORD_BUFFER (N_WORD_BUFFER)
  ) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (rd_acc),
    .i_clr   (i_flush),
    .o_ptr   (rd_ptr)
  );

  fifo_level_ptr #(
    .N_WORD_BUFFER (N_WORD_BUFFER)
  ) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (wr_acc),
    .i_clr   (i_flush),
    .o_ptr   (wr_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else if (wr_acc && !rd_acc) begin
      count_d = count_q + NB_COUNT'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - NB_COUNT'(1);
    end
  end

  // Clear first, then OR in this cycle's rejection so a rejection wins.
  always_comb begin
    overflow_d  = i_clr_err ? 1'b0 : overflow_q;
    underflow_d = i_clr_err ? 1'b0 : underflow_q;
    overflow_d  = overflow_d  | wr_rej;
    underflow_d = underflow_d | rd_rej;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset so it can map onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr] <= i_data;
    end
  end

  assign o_data         = mem_q[rd_ptr];
  assign o_fifo_empty   = empty;
  assign o_fifo_full    = full;
  assign o_almost_empty = (count_q <= COUNT_AE);
  assign o_almost_full  = (count_q >= COUNT_AF);
  assign o_count        = count_q;
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_level.sv
// tb/tb_fifo_level.sv - self-checking bench for fifo_level

module tb_fifo_level;

  localparam int NB_WORD  = 8;
  localparam int DEPTH    = 5;
  localparam int NB_COUNT = $clog2(DEPTH + 1);

  logic                clk;
  logic                rst_n;
  logic [NB_WORD-1:0]  data_in;
  logic                wr;
  logic                rd;
  logic                flush;
  logic                clr_err;
  logic [NB_WORD-1:0]  data_out;
  logic                empty;
  logic                full;
  logic                aempty;
  logic                afull;
  logic [NB_COUNT-1:0] count;
  logic                ovf;
  logic                unf;

  int total = 0;
  int bad   = 0;

  fifo_level #(
    .NB_WORD        (NB_WORD),
    .N_WORD_BUFFER  (DEPTH),
    .N_ALMOST_FULL  (4),
    .N_ALMOST_EMPTY (1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_data         (data_in),
    .i_write        (wr),
    .i_read         (rd),
    .i_flush        (flush),
    .i_clr_err      (clr_err),
    .o_data         (data_out),
    .o_fifo_empty   (empty),
    .o_fifo_full    (full),
    .o_almost_empty (aempty),
    .o_almost_full  (afull),
    .o_count        (count),
    .o_overflow     (ovf),
    .o_underflow    (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       r;
    logic       f;
    logic       c;
    logic [7:0] d;
    int         e_count;
    logic       chk_data;
    logic [7:0] e_data;
    logic       e_empty;
    logic       e_full;
    logic       e_ae;
    logic       e_af;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected flags derived from the expected count (AF=4, AE=1, depth 5).
  task automatic add(input logic w, input logic r, input logic f, input logic c,
                     input logic [7:0] d, input int e_count, input logic chk,
                     input logic [7:0] e_data, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.w = w; v.r = r; v.f = f; v.c = c; v.d = d;
    v.e_count  = e_count;
    v.chk_data = chk;
    v.e_data   = e_data;
    v.e_empty  = (e_count == 0);
    v.e_full   = (e_count == DEPTH);
    v.e_ae     = (e_count <= 1);
    v.e_af     = (e_count >= 4);
    v.e_ovf    = e_ovf;
    v.e_unf    = e_unf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic w, input logic r, input logic f, input logic c,
                       input logic [7:0] d);
    wr = w; rd = r; flush = f; clr_err = c; data_in = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},  32'(count), 32'd0);
    check({tag, "_empty"},  32'(empty), 32'd1);
    check({tag, "_full"},   32'(full),  32'd0);
    check({tag, "_aempty"}, 32'(aempty), 32'd1);
    check({tag, "_afull"},  32'(afull), 32'd0);
    check({tag, "_ovf"},    32'(ovf),   32'd0);
    check({tag, "_unf"},    32'(unf),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = '0;

    //   w  r  f  c  data   cnt chk data   ovf unf
    add(1, 0, 0, 0, 8'h11, 1, 1, 8'h11, 0, 0);
    add(1, 0, 0, 0, 8'h22, 2, 1, 8'h11, 0, 0);
    add(1, 0, 0, 0, 8'h33, 3, 1, 8'h11, 0, 0);
    add(0, 1, 0, 0, 8'h00, 2, 1, 8'h22, 0, 0);
    add(0, 1, 0, 0, 8'h00, 1, 1, 8'h33, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(1, 0, 0, 0, 8'h01, 1, 1, 8'h01, 0, 0);
    add(1, 0, 0, 0, 8'h02, 2, 1, 8'h01, 0, 0);
    add(1, 0, 0, 0, 8'h03, 3, 1, 8'h01, 0, 0);
    add(1, 0, 0, 0, 8'h04, 4, 1, 8'h01, 0, 0);
    add(1, 0, 0, 0, 8'h05, 5, 1, 8'h01, 0, 0);
    add(1, 0, 0, 0, 8'h06, 5, 1, 8'h01, 1, 0);  // rejected push
    add(1, 1, 0, 0, 8'hAA, 5, 1, 8'h02, 1, 0);  // full: push+pop
    add(0, 1, 0, 0, 8'h00, 4, 1, 8'h03, 1, 0);
    add(0, 1, 0, 0, 8'h00, 3, 1, 8'h04, 1, 0);
    add(0, 1, 0, 0, 8'h00, 2, 1, 8'h05, 1, 0);
    add(0, 1, 0, 0, 8'h00, 1, 1, 8'hAA, 1, 0);
    add(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    add(1, 1, 0, 0, 8'hBB, 1, 1, 8'hBB, 1, 1);  // empty: push ok, pop rejected
    add(0, 0, 0, 1, 8'h00, 1, 1, 8'hBB, 0, 0);  // clear errors
    add(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(1, 0, 0, 0, 8'hC1, 1, 1, 8'hC1, 0, 0);  // wrap rounds
    add(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(1, 0, 0, 0, 8'hC2, 1, 1, 8'hC2, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(1, 0, 0, 0, 8'hC3, 1, 1, 8'hC3, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(1, 0, 0, 0, 8'hD1, 1, 1, 8'hD1, 0, 0);
    add(1, 0, 0, 0, 8'hD2, 2, 1, 8'hD1, 0, 0);
    add(1, 0, 0, 0, 8'hD3, 3, 1, 8'hD1, 0, 0);
    add(1, 1, 1, 0, 8'hD4, 0, 0, 8'h00, 0, 0);  // flush ignores push/pop
    add(1, 0, 0, 0, 8'hE1, 1, 1, 8'hE1, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1);  // rejected pop
    add(0, 1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 1);  // clr_err loses to rejection

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].w, vecs[i].r, vecs[i].f, vecs[i].c, vecs[i].d);
      check($sformatf("v%0d_count", i),  32'(count),  32'(vecs[i].e_count));
      check($sformatf("v%0d_empty", i),  32'(empty),  32'(vecs[i].e_empty));
      check($sformatf("v%0d_full", i),   32'(full),   32'(vecs[i].e_full));
      check($sformatf("v%0d_aempty", i), 32'(aempty), 32'(vecs[i].e_ae));
      check($sformatf("v%0d_afull", i),  32'(afull),  32'(vecs[i].e_af));
      check($sformatf("v%0d_ovf", i),    32'(ovf),    32'(vecs[i].e_ovf));
      check($sformatf("v%0d_unf", i),    32'(unf),    32'(vecs[i].e_unf));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_data", i), 32'(data_out), 32'(vecs[i].e_data));
      end
    end

    // Mid-operation asynchronous reset: reach count=2 with overflow set.
    drive(0, 0, 0, 1, 8'h00);
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 0, 8'(8'h40 + k));
    end
    check("pre_rst_full", 32'(full), 32'd1);
    check("pre_rst_ovf",  32'(ovf),  32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 8'h00);
    end
    check("pre_rst_count", 32'(count), 32'd2);
    check("pre_rst_data",  32'(data_out), 32'h43);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 8'h5A);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_data",  32'(data_out), 32'h5A);
    check("post_rst_empty", 32'(empty), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
